is_uart_rx_param: RTL and testbench

//  Parametrised UART receiver core with oversampling, configurable frame format and valid/ready output.

---
 rtl/is_uart_rx_param_pkg.sv | 39 +++
 rtl/is_uart_rx_param.sv | 192 +++++++++++++++++++
 tb/tb_is_uart_rx_param.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/is_uart_rx_param_pkg.sv
// Shared UART controller types: parity modes, receiver FSM states and the
// parity expectation helper used by the receiver core.
package is_pkg_uart_controller;

  typedef enum logic [2:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_MARK,
    PAR_SPACE
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WEND
  } rx_state_t;

  localparam int unsigned RX_DATA_MAX = 8;

  // Narrower frames are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic rx_par_expect(input logic [RX_DATA_MAX-1:0] data,
                                         input parity_mode_t mode);
    logic exp_bit;
    exp_bit = 1'b0;
    case (mode)
      PAR_EVEN:  exp_bit = ^data;
      PAR_ODD:   exp_bit = ~^data;
      PAR_MARK:  exp_bit = 1'b1;
      PAR_SPACE: exp_bit = 1'b0;
      default:   exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/is_uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready output.
// Optional break detection is enabled by defining IS_UART_RX_BREAK_DET_EN.
module is_uart_rx_param
  import is_pkg_uart_controller::*;
#(
  parameter int unsigned  DATA_W      = 8,
  parameter parity_mode_t PARITY_MODE = PAR_NONE,
  parameter int unsigned  STOP_BITS   = 1,
  parameter int unsigned  OVS         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_ce_i,
  input  logic              rxd_rg_i,
  input  logic              rx_ready_i,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              rxct_r_o,
  output logic              break_o
);

  localparam int unsigned   OW        = $clog2(OVS);
  localparam logic [OW-1:0] OS_MID    = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVS - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_t         state, state_n;
  logic [OW-1:0]     os_cnt, os_cnt_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              armed, armed_n;
  logic              par_err, par_err_n;
  logic              frm_err, frm_err_n;
  logic              load;
  logic              bit_tick;
`ifdef IS_UART_RX_BREAK_DET_EN
  logic              zero, zero_n;
  logic              brk;
`endif

  assign bit_tick = rx_ce_i && (os_cnt == OS_LAST);
  assign rxct_r_o = (state == IDLE);

  always_comb begin
    state_n   = state;
    os_cnt_n  = os_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    armed_n   = armed;
    par_err_n = par_err;
    frm_err_n = frm_err;
    load      = 1'b0;
`ifdef IS_UART_RX_BREAK_DET_EN
    zero_n    = zero;
    brk       = 1'b0;
`endif
    // Every bit after the start mid-point is one full OVS period apart.
    if (rx_ce_i && (state == DATA || state == PARITY || state == STOP)) begin
      os_cnt_n = bit_tick ? '0 : os_cnt + OW'(1);
    end
    case (state)
      IDLE: begin
        if (rx_ce_i) begin
          if (rxd_rg_i) begin
            armed_n = 1'b1;
          end else if (armed) begin
            state_n   = START;
            os_cnt_n  = '0;
            bit_cnt_n = '0;
            par_err_n = 1'b0;
            frm_err_n = 1'b0;
`ifdef IS_UART_RX_BREAK_DET_EN
            zero_n    = 1'b1;
`endif
          end
        end
      end
      START: begin
        if (rx_ce_i) begin
          if (os_cnt == OS_MID) begin
            os_cnt_n = '0;
            state_n  = rxd_rg_i ? IDLE : DATA;
          end else begin
            os_cnt_n = os_cnt + OW'(1);
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          shreg_n = {rxd_rg_i, shreg[DATA_W-1:1]};
`ifdef IS_UART_RX_BREAK_DET_EN
          zero_n  = zero & ~rxd_rg_i;
`endif
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            state_n   = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_err_n = rxd_rg_i != rx_par_expect(RX_DATA_MAX'(shreg), PARITY_MODE);
`ifdef IS_UART_RX_BREAK_DET_EN
          zero_n    = zero & ~rxd_rg_i;
`endif
          state_n   = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          frm_err_n = frm_err | ~rxd_rg_i;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
`ifdef IS_UART_RX_BREAK_DET_EN
            if (zero && !rxd_rg_i) brk = 1'b1;
            else                   load = 1'b1;
`else
            load = 1'b1;
`endif
            state_n = rxd_rg_i ? IDLE : WEND;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
`ifdef IS_UART_RX_BREAK_DET_EN
            zero_n    = zero & ~rxd_rg_i;
`endif
          end
        end
      end
      WEND: begin
        if (rxd_rg_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      armed        <= 1'b0;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      rx_valid_o   <= 1'b0;
      rx_data_o    <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      state   <= state_n;
      os_cnt  <= os_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      armed   <= armed_n;
      par_err <= par_err_n;
      frm_err <= frm_err_n;
      if (load) begin
        rx_valid_o   <= 1'b1;
        rx_data_o    <= shreg;
        parity_err_o <= par_err;
        frame_err_o  <= frm_err_n;
        if (rx_valid_o && !rx_ready_i) overrun_o <= 1'b1;
        else if (rx_valid_o)           overrun_o <= 1'b0;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
        overrun_o  <= 1'b0;
      end
    end
  end

`ifdef IS_UART_RX_BREAK_DET_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zero    <= 1'b0;
      break_o <= 1'b0;
    end else begin
      zero    <= zero_n;
      break_o <= brk;
    end
  end
`else
  assign break_o = 1'b0;
`endif

endmodule

// File: tb/tb_is_uart_rx_param.sv
// Scoreboard bench for is_uart_rx_param: three instances (8N1, 8E1, 8N2) on
// separate serial lines, shared clock, reset and oversample tick.
module tb_is_uart_rx_param;
  import is_pkg_uart_controller::*;

  localparam int unsigned OVS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce = 1'b0;
  logic       rxd   [3];
  logic       ready [3];
  logic       valid [3];
  logic [7:0] data  [3];
  logic       perr  [3];
  logic       ferr  [3];
  logic       ovr   [3];
  logic       rxct  [3];
  logic       brk   [3];

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   brk_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) ce <= ~ce;
  always @(posedge clk) if (brk[0] === 1'b1) brk_cnt <= brk_cnt + 1;

  is_uart_rx_param #(.DATA_W(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(1), .OVS(OVS)) dut_8n1 (
    .clk_i(clk), .rst_i(rst), .rx_ce_i(ce), .rxd_rg_i(rxd[0]), .rx_ready_i(ready[0]),
    .rx_valid_o(valid[0]), .rx_data_o(data[0]), .parity_err_o(perr[0]), .frame_err_o(ferr[0]),
    .overrun_o(ovr[0]), .rxct_r_o(rxct[0]), .break_o(brk[0]));

  is_uart_rx_param #(.DATA_W(8), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1), .OVS(OVS)) dut_8e1 (
    .clk_i(clk), .rst_i(rst), .rx_ce_i(ce), .rxd_rg_i(rxd[1]), .rx_ready_i(ready[1]),
    .rx_valid_o(valid[1]), .rx_data_o(data[1]), .parity_err_o(perr[1]), .frame_err_o(ferr[1]),
    .overrun_o(ovr[1]), .rxct_r_o(rxct[1]), .break_o(brk[1]));

  is_uart_rx_param #(.DATA_W(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(2), .OVS(OVS)) dut_8n2 (
    .clk_i(clk), .rst_i(rst), .rx_ce_i(ce), .rxd_rg_i(rxd[2]), .rx_ready_i(ready[2]),
    .rx_valid_o(valid[2]), .rx_data_o(data[2]), .parity_err_o(perr[2]), .frame_err_o(ferr[2]),
    .overrun_o(ovr[2]), .rxct_r_o(rxct[2]), .break_o(brk[2]));

  task automatic tick();
    do @(posedge clk); while (ce !== 1'b1);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // bits[0] goes out first; each bit is held for one full bit period.
  task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int i = 0; i < n; i++) begin
      rxd[sel] = b[i];
      ticks(OVS);
    end
  endtask

  task automatic check_frame(input int sel, input logic exp_ovr, input string name);
    exp_t e;
    int   waited;
    waited = 0;
    while (valid[sel] !== 1'b1 && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (valid[sel] !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b expected 1", name, valid[sel]);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty expected entry", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (data[sel] !== e.data) begin
        errors++;
        $display("FAIL %s data: got %h expected %h", name, data[sel], e.data);
      end
      checks++;
      if (perr[sel] !== e.perr) begin
        errors++;
        $display("FAIL %s parity_err: got %b expected %b", name, perr[sel], e.perr);
      end
      checks++;
      if (ferr[sel] !== e.ferr) begin
        errors++;
        $display("FAIL %s frame_err: got %b expected %b", name, ferr[sel], e.ferr);
      end
    end
    checks++;
    if (ovr[sel] !== exp_ovr) begin
      errors++;
      $display("FAIL %s overrun: got %b expected %b", name, ovr[sel], exp_ovr);
    end
    ready[sel] = 1'b1;
    @(posedge clk); #1;
    ready[sel] = 1'b0;
    checks++;
    if (valid[sel] !== 1'b0 || ovr[sel] !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake clear: got valid=%b overrun=%b expected 0/0",
               name, valid[sel], ovr[sel]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd[0] = 1'b0; rxd[1] = 1'b1; rxd[2] = 1'b1;
    for (int i = 0; i < 3; i++) ready[i] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid[i] !== 1'b0 || data[i] !== 8'h00 || perr[i] !== 1'b0 || ferr[i] !== 1'b0 ||
          ovr[i] !== 1'b0 || brk[i] !== 1'b0 || rxct[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: got v=%b d=%h p=%b f=%b o=%b b=%b c=%b expected 0 00 0 0 0 0 1",
                 i, valid[i], data[i], perr[i], ferr[i], ovr[i], brk[i], rxct[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Line low straight out of reset must not start a frame before arming.
    ticks(20);
    checks++;
    if (rxct[0] !== 1'b1 || valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL unarmed: got rxct=%b valid=%b expected 1/0", rxct[0], valid[0]);
    end
    rxd[0] = 1'b1;
    ticks(3);
  endtask

  task automatic test_8n1();
    sb.push_back('{sel: 0, data: 8'hA5, perr: 1'b0, ferr: 1'b0});
    rxd[0] = 1'b0;
    ticks(OVS);
    checks++;
    if (rxct[0] !== 1'b0) begin
      errors++;
      $display("FAIL 8n1 busy: got rxct=%b expected 0", rxct[0]);
    end
    send_bits(0, {7'h7f, 1'b1, 8'hA5}, 9);
    check_frame(0, 1'b0, "8n1_a5");
    checks++;
    if (rxct[0] !== 1'b1) begin
      errors++;
      $display("FAIL 8n1 idle: got rxct=%b expected 1", rxct[0]);
    end
  endtask

  task automatic test_parity();
    ticks(2);
    sb.push_back('{sel: 1, data: 8'h07, perr: 1'b1, ferr: 1'b0});
    send_bits(1, {5'h1f, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    check_frame(1, 1'b0, "8e1_bad_par");
    ticks(2);
    sb.push_back('{sel: 1, data: 8'h07, perr: 1'b0, ferr: 1'b0});
    send_bits(1, {5'h1f, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    check_frame(1, 1'b0, "8e1_good_par");
  endtask

  task automatic test_stop2();
    ticks(2);
    sb.push_back('{sel: 2, data: 8'h5A, perr: 1'b0, ferr: 1'b1});
    send_bits(2, {5'h1f, 1'b0, 1'b1, 8'h5A, 1'b0}, 11);
    ticks(4);
    checks++;
    if (rxct[2] !== 1'b0) begin
      errors++;
      $display("FAIL 8n2 wend: got rxct=%b expected 0", rxct[2]);
    end
    check_frame(2, 1'b0, "8n2_stop2_low");
    rxd[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rxct[2] !== 1'b1) begin
      errors++;
      $display("FAIL 8n2 wend exit: got rxct=%b expected 1", rxct[2]);
    end
    ticks(2);
    sb.push_back('{sel: 2, data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    send_bits(2, {5'h1f, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    check_frame(2, 1'b0, "8n2_3c");
  endtask

  task automatic test_false_start();
    ticks(2);
    rxd[0] = 1'b0;
    ticks(4);
    rxd[0] = 1'b1;
    ticks(24);
    checks++;
    if (valid[0] !== 1'b0 || rxct[0] !== 1'b1) begin
      errors++;
      $display("FAIL false_start: got valid=%b rxct=%b expected 0/1", valid[0], rxct[0]);
    end
  endtask

  task automatic test_overrun();
    ticks(2);
    sb.push_back('{sel: 0, data: 8'h11, perr: 1'b0, ferr: 1'b0});
    send_bits(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10);
    ticks(2);
    // The unconsumed frame is overwritten, so its entry leaves the scoreboard.
    if (valid[0] === 1'b1 && sb.size() > 0) sb.delete(0);
    sb.push_back('{sel: 0, data: 8'h22, perr: 1'b0, ferr: 1'b0});
    send_bits(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10);
    check_frame(0, 1'b1, "overrun_22");
  endtask

  task automatic test_break();
    int b0;
    ticks(2);
    b0 = brk_cnt;
`ifndef IS_UART_RX_BREAK_DET_EN
    sb.push_back('{sel: 0, data: 8'h00, perr: 1'b0, ferr: 1'b1});
`endif
    rxd[0] = 1'b0;
    ticks(12 * OVS);
    rxd[0] = 1'b1;
    ticks(4);
`ifdef IS_UART_RX_BREAK_DET_EN
    checks++;
    if (brk_cnt - b0 !== 1) begin
      errors++;
      $display("FAIL break pulses: got %0d expected 1", brk_cnt - b0);
    end
    checks++;
    if (valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL break valid: got %b expected 0", valid[0]);
    end
`else
    checks++;
    if (brk_cnt - b0 !== 0) begin
      errors++;
      $display("FAIL break pulses: got %0d expected 0", brk_cnt - b0);
    end
    check_frame(0, 1'b0, "break_as_data");
`endif
    checks++;
    if (rxct[0] !== 1'b1) begin
      errors++;
      $display("FAIL break idle: got rxct=%b expected 1", rxct[0]);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_false_start();
    test_overrun();
    test_break();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
